// File: rtl/alu_operand_stage.sv
// Operand-select and register stage between register-file read and the ALU.
// Optional write-back forwarding is enabled by defining ALU_OPERAND_FWD_EN.
module alu_operand_stage #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 8,
  parameter int OP_W   = 4,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_in,
  output logic              ready_out,
  input  logic              flush,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] rd_q,
  input  logic [DATA_W-1:0] rs_q,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [1:0]        b_sel,
  input  logic [OP_W-1:0]   op_in,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              alu_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic              en_out
);

  localparam int PAD_W = DATA_W - IMM_W;

  logic              accept;
  logic [DATA_W-1:0] a_src;
  logic [DATA_W-1:0] rs_src;
  logic [DATA_W-1:0] b_mux;

  assign ready_out = !en_out || alu_ready;
  assign accept    = en_in && ready_out && !flush;

`ifdef ALU_OPERAND_FWD_EN
  always_comb begin
    a_src  = rd_q;
    rs_src = rs_q;
    if (wb_en && (wb_addr == rd_addr)) a_src  = wb_data;
    if (wb_en && (wb_addr == rs_addr)) rs_src = wb_data;
  end
`else
  // Forwarding ports are kept for a stable interface but carry no logic here.
  logic unused_fwd;
  assign unused_fwd = ^{wb_en, wb_addr, wb_data, rd_addr, rs_addr};
  assign a_src      = rd_q;
  assign rs_src     = rs_q;
`endif

  always_comb begin
    b_mux = '0;
    case (b_sel)
      2'b00:   b_mux = {{PAD_W{imm[IMM_W-1]}}, imm};
      2'b01:   b_mux = rs_src;
      2'b10:   b_mux = {{PAD_W{1'b0}}, imm};
      default: b_mux = {imm, {PAD_W{1'b0}}};
    endcase
  end

  // Flush wins over accept and hold; data registers only move on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      en_out <= 1'b0;
    end else if (flush) begin
      en_out <= 1'b0;
    end else if (accept) begin
      alu_a  <= a_src;
      alu_b  <= b_mux;
      alu_op <= op_in;
      en_out <= 1'b1;
    end else if (alu_ready) begin
      en_out <= 1'b0;
    end
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Parametrised operand-select and register stage between register-file read and the ALU.
- Registers operand A, operand B and the ALU opcode, with a valid/ready handshake so a stalled ALU holds the stage.
- Adds to the single-mode 16-bit operand mux:
  - four operand-B immediate/register modes;
  - flush;
  - back-pressure;
  - optional write-back forwarding.

Parameters:
- DATA_W, 16, operand and register data width. Legal range 2..64.
- IMM_W, 8, immediate field width. Must satisfy 1 <= IMM_W < DATA_W.
- OP_W, 4, ALU opcode width, passed through unchanged.
- REG_AW, 3, register address width. Used only for forwarding compares.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- en_in  in  1  input valid: operands on rd_q/rs_q/imm/op are valid this cycle.
- ready_out  out  1  stage can accept input this cycle.
- flush  in  1  synchronous kill of the held and incoming operation.
- imm  in  IMM_W  immediate field.
- rd_q  in  DATA_W  register-file read data for operand A.
- rs_q  in  DATA_W  register-file read data for operand B.
- rd_addr  in  REG_AW  register address of rd_q.
- rs_addr  in  REG_AW  register address of rs_q.
- b_sel  in  2  operand-B mode, sampled with en_in:
  - 00: sign-extended imm;
  - 01: rs_q;
  - 10: zero-extended imm;
  - 11: imm placed in the upper IMM_W bits, low DATA_W-IMM_W bits zero.
- op_in  in  OP_W  ALU opcode.
- wb_en  in  1  write-back valid (forwarding).
- wb_addr  in  REG_AW  write-back register address.
- wb_data  in  DATA_W  write-back data.
- alu_ready  in  1  ALU accepts the registered operation.
- alu_a  out  DATA_W  registered operand A.
- alu_b  out  DATA_W  registered operand B.
- alu_op  out  OP_W  registered opcode.
- en_out  out  1  registered outputs are valid.

Behaviour:
- Reset (rst low, asynchronous): alu_a=0, alu_b=0, alu_op=0, en_out=0. Release is synchronous to the next clk edge; no operation is captured during reset.
- ready_out is combinational: ready_out = !en_out || alu_ready. It does not depend on en_in.
- Accept: en_in && ready_out && !flush. On the next rising edge:
  - alu_a <= A_src;
  - alu_b <= B_mux(b_sel);
  - alu_op <= op_in;
  - en_out <= 1.
- Latency: one cycle from accept to en_out.
- Drain: en_out && alu_ready && !accept gives en_out <= 0 next edge. Data registers keep their last values.
- Hold: en_out && !alu_ready gives all outputs stable. en_in is ignored because ready_out=0. Upstream must hold its inputs.
- Back-to-back: en_out && alu_ready && accept loads the new operation with en_out staying 1. Full throughput, no bubble.
- Flush: flush=1 gives en_out <= 0 next edge, whatever en_in and alu_ready are. Data registers are unchanged. Flush has priority over accept and hold.
- Idle (!en_out, !en_in): registers unchanged, en_out stays 0.
- Sign extension: bit IMM_W-1 of imm is replicated into the upper DATA_W-IMM_W bits.
- Mode 11 is the concatenation {imm, zeros}. No truncation occurs because IMM_W < DATA_W.
- A_src is rd_q; B register source is rs_q. Both can be replaced by forwarding (see Optional Feature).
- Sampling: b_sel, imm and op_in are sampled only on accept. Changes at any other time have no effect.

Optional Feature:
- Macro: ALU_OPERAND_FWD_EN.
- Defined:
  - if wb_en && wb_addr==rd_addr, A_src = wb_data;
  - if wb_en && wb_addr==rs_addr, the register source for b_sel=01 is wb_data;
  - both operands may forward in the same cycle;
  - immediate modes never forward;
  - forwarding is evaluated only in the accept cycle.
- Not defined:
  - wb_en, wb_addr, wb_data, rd_addr and rs_addr are present but ignored;
  - A_src is always rd_q and the B register source is always rs_q;
  - no compare logic is synthesised.

Test Plan:
- Reset: assert rst low mid-operation with en_out=1, alu_a=0x1234 -> all outputs 0 immediately, without waiting for a clock edge; en_out stays 0 after release until a new accept.
- Immediate modes: rd_q=0x0005, imm=0xF0, alu_ready=1, with b_sel 00/10/11 on successive cycles ->
  - alu_b = 0xFFF0, 0x00F0, 0xF000 respectively;
  - alu_a=0x0005 each cycle;
  - en_out high for 3 consecutive cycles, then low.
- Back-pressure: hold alu_ready=0 with en_out=1 (alu_b=0x00AA), and drive en_in=1 with rs_q=0x0055, b_sel=01 ->
  - ready_out=0 and outputs remain 0x00AA;
  - raise alu_ready -> next edge alu_b=0x0055, en_out=1.
- Flush: drive flush=1 together with en_in=1 and alu_ready=0 -> en_out=0 next edge, alu_a/alu_b unchanged; following en_in with alu_ready=1 captures normally.
- Forwarding, with ALU_OPERAND_FWD_EN defined:
  - rd_addr=3, rs_addr=3, rd_q=0x1111, rs_q=0x2222, wb_en=1, wb_addr=3, wb_data=0xBEEF, b_sel=01 -> alu_a=0xBEEF, alu_b=0xBEEF;
  - same stimulus without the macro -> alu_a=0x1111, alu_b=0x2222.
- Width parametrisation: DATA_W=32, IMM_W=12, imm=0x800, b_sel=00 -> alu_b=0xFFFFF800; b_sel=11 -> alu_b=0x80000000.
